// File: rtl/hwpe_tcdm_arb_package.sv
// ----------------------------------------------------------------------------
// hwpe_tcdm_arb_package
// Shared types for the HWPE TCDM round-robin arbiter and its in-flight ID FIFO.
//   req_idx_t   : requester index as stored in the ID FIFO (up to 256 ports)
//   rsp_route_t : response routing decision (valid + destination requester)
// ----------------------------------------------------------------------------
package hwpe_tcdm_arb_package;

    localparam int unsigned REQ_IDX_W = 8;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t id;
    } rsp_route_t;

endpackage : hwpe_tcdm_arb_package

// File: rtl/hwpe_tcdm_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// hwpe_tcdm_arb_id_fifo
// In-flight requester-ID FIFO. Synchronous, registered full/empty flags,
// occupancy count output. Push while full and pop while empty are ignored.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_id_i into the tail
//   push_id_i    : requester index to store
//   pop_i        : drop the head entry
//   head_o       : oldest stored requester index
//   full_o       : registered full flag
//   empty_o      : registered empty flag
//   count_o      : registered occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module hwpe_tcdm_arb_id_fifo
    import hwpe_tcdm_arb_package::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  req_idx_t               push_id_i,
    input  logic                   pop_i,
    output req_idx_t               head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;
    req_idx_t         mem_q [DEPTH];

    // Pointer/occupancy update; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        do_push  = push_i & ~full_q;
        do_pop   = pop_i & ~empty_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage, no reset needed: entries are only read while valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule : hwpe_tcdm_arb_id_fifo

// File: rtl/hwpe_tcdm_rr_arbiter.sv
// ----------------------------------------------------------------------------
// hwpe_tcdm_rr_arbiter
// Round-robin arbiter of N_REQ TCDM requester ports onto one TCDM master.
// Grant order is tracked in an ID FIFO so in-order responses are routed back
// to the requester that issued them.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_req/in_gnt                 : per-requester request / grant
//   in_add/in_wen/in_be/in_data   : per-requester request payload
//   in_r_data/in_r_valid          : per-requester response
//   out_req/out_add/out_wen/out_be/out_data : shared master request
//   out_gnt/out_r_data/out_r_valid          : shared master grant / response
//   outstanding                   : in-flight transaction count
//   err_unexp_rvalid              : sticky, response seen with nothing in flight
// ----------------------------------------------------------------------------
module hwpe_tcdm_rr_arbiter
    import hwpe_tcdm_arb_package::*;
#(
    parameter int unsigned N_REQ           = 3,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     in_req,
    output logic [N_REQ-1:0]                     in_gnt,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     in_add,
    input  logic [N_REQ-1:0]                     in_wen,
    input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]   in_be,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     in_data,
    output logic [N_REQ-1:0][DATA_WIDTH-1:0]     in_r_data,
    output logic [N_REQ-1:0]                     in_r_valid,
    output logic                                 out_req,
    output logic [ADDR_WIDTH-1:0]                out_add,
    output logic                                 out_wen,
    output logic [DATA_WIDTH/8-1:0]              out_be,
    output logic [DATA_WIDTH-1:0]                out_data,
    input  logic                                 out_gnt,
    input  logic [DATA_WIDTH-1:0]                out_r_data,
    input  logic                                 out_r_valid,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_unexp_rvalid
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] winner;
    int unsigned      scan_idx;
    logic             any_req;
    logic             handshake;
    logic             fifo_full, fifo_empty;
    req_idx_t         fifo_head;
    logic [CNT_W-1:0] fifo_count;
    rsp_route_t       route;
    logic             err_q, err_d;

    // First asserted request at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (!any_req && in_req[IDX_W'(scan_idx)]) begin
                any_req = 1'b1;
                winner  = IDX_W'(scan_idx);
            end
        end
    end

    // Master request side; full is registered so a same-cycle pop never frees a slot
    always_comb begin
        out_req   = ~rst & any_req & ~fifo_full;
        handshake = out_req & out_gnt;
        out_add   = '0;
        out_wen   = 1'b0;
        out_be    = '0;
        out_data  = '0;
        if (out_req) begin
            out_add  = in_add[winner];
            out_wen  = in_wen[winner];
            out_be   = in_be[winner];
            out_data = in_data[winner];
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            in_gnt[k] = handshake && (winner == IDX_W'(k));
        end
    end

    // Pointer moves just past the winner only on an accepted transaction
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    // Response routing to the oldest in-flight requester
    always_comb begin
        route.valid = ~rst & out_r_valid & ~fifo_empty;
        route.id    = fifo_head;
        err_d       = err_q | (out_r_valid & fifo_empty);
        for (int unsigned k = 0; k < N_REQ; k++) begin
            in_r_valid[k] = route.valid && (route.id == REQ_IDX_W'(k));
            in_r_data[k]  = rst ? '0 : out_r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    hwpe_tcdm_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) i_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (handshake),
        .push_id_i (REQ_IDX_W'(winner)),
        .pop_i     (route.valid),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Status outputs forced low while reset is held
    assign outstanding      = rst ? '0 : fifo_count;
    assign err_unexp_rvalid = ~rst & err_q;

endmodule : hwpe_tcdm_rr_arbiter

// File: tb/tb_hwpe_tcdm_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_hwpe_tcdm_rr_arbiter
// Self-checking bench: table of per-cycle vectors with expected grant winner,
// out_req, occupancy and error flag; a queue of granted requester indices
// predicts which port each response is routed to.
// ----------------------------------------------------------------------------
module tb_hwpe_tcdm_rr_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned MO = 4;
    localparam int unsigned CW = $clog2(MO) + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           in_req, in_gnt, in_wen, in_r_valid;
    logic [N-1:0][AW-1:0]   in_add;
    logic [N-1:0][BW-1:0]   in_be;
    logic [N-1:0][DW-1:0]   in_data, in_r_data;
    logic                   out_req, out_wen, out_gnt, out_r_valid;
    logic [AW-1:0]          out_add;
    logic [BW-1:0]          out_be;
    logic [DW-1:0]          out_data, out_r_data;
    logic [CW-1:0]          outstanding;
    logic                   err_unexp_rvalid;

    always #5 clk = ~clk;

    hwpe_tcdm_rr_arbiter #(
        .N_REQ           (N),
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_req           (in_req),
        .in_gnt           (in_gnt),
        .in_add           (in_add),
        .in_wen           (in_wen),
        .in_be            (in_be),
        .in_data          (in_data),
        .in_r_data        (in_r_data),
        .in_r_valid       (in_r_valid),
        .out_req          (out_req),
        .out_add          (out_add),
        .out_wen          (out_wen),
        .out_be           (out_be),
        .out_data         (out_data),
        .out_gnt          (out_gnt),
        .out_r_data       (out_r_data),
        .out_r_valid      (out_r_valid),
        .outstanding      (outstanding),
        .err_unexp_rvalid (err_unexp_rvalid)
    );

    typedef struct {
        logic          rst;
        logic [2:0]    req;
        logic          gnt;
        logic          rv;
        logic [1:0]    win;
        logic          oreq;
        logic [CW-1:0] outst;
        logic          err;
    } vec_t;

    vec_t          tv[$];
    logic [1:0]    sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    // Fixed, distinct per-port payloads
    logic [AW-1:0] port_add  [N];
    logic          port_wen  [N];
    logic [BW-1:0] port_be   [N];
    logic [DW-1:0] port_data [N];

    function automatic vec_t mk(input logic r, input logic [2:0] q, input logic g,
                                input logic v, input logic [1:0] w, input logic o,
                                input logic [CW-1:0] c, input logic e);
        vec_t t;
        t.rst = r; t.req = q; t.gnt = g; t.rv = v;
        t.win = w; t.oreq = o; t.outst = c; t.err = e;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the edge, then wait for the opposite edge
    task automatic drive(input logic r, input logic [2:0] q, input logic g,
                         input logic v, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        rst         = r;
        in_req      = q;
        out_gnt     = g;
        out_r_valid = v;
        out_r_data  = d;
        @(negedge clk);
    endtask

    // Compare all outputs; scoreboard pops on a response, pushes on a grant
    task automatic check_outputs(input int idx, input logic v_rst, input logic v_gnt,
                                 input logic v_rv, input logic [DW-1:0] v_rdata,
                                 input logic exp_oreq, input logic [1:0] exp_win,
                                 input logic [CW-1:0] exp_outst, input logic exp_err);
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rv;
        logic [AW-1:0] exp_add;
        logic          exp_wen;
        logic [BW-1:0] exp_be;
        logic [DW-1:0] exp_data;
        logic [1:0]    head;
        exp_gnt  = '0;
        exp_rv   = '0;
        exp_add  = '0;
        exp_wen  = 1'b0;
        exp_be   = '0;
        exp_data = '0;
        if (exp_oreq) begin
            exp_add  = port_add[exp_win];
            exp_wen  = port_wen[exp_win];
            exp_be   = port_be[exp_win];
            exp_data = port_data[exp_win];
            if (v_gnt) exp_gnt[exp_win] = 1'b1;
        end
        if (v_rst) begin
            sb.delete();
        end else if (v_rv && sb.size() > 0) begin
            head = sb.pop_front();
            exp_rv[head] = 1'b1;
        end
        if (exp_gnt != '0) sb.push_back(exp_win);

        chk("out_req",     idx, 64'(out_req),          64'(exp_oreq));
        chk("in_gnt",      idx, 64'(in_gnt),           64'(exp_gnt));
        chk("out_add",     idx, 64'(out_add),          64'(exp_add));
        chk("out_wen",     idx, 64'(out_wen),          64'(exp_wen));
        chk("out_be",      idx, 64'(out_be),           64'(exp_be));
        chk("out_data",    idx, 64'(out_data),         64'(exp_data));
        chk("in_r_valid",  idx, 64'(in_r_valid),       64'(exp_rv));
        chk("outstanding", idx, 64'(outstanding),      64'(exp_outst));
        chk("err_unexp",   idx, 64'(err_unexp_rvalid), 64'(exp_err));
        if (v_rst) begin
            for (int k = 0; k < N; k++) chk("in_r_data_rst", idx, 64'(in_r_data[k]), 64'(0));
        end else if (v_rv) begin
            for (int k = 0; k < N; k++) chk("in_r_data", idx, 64'(in_r_data[k]), 64'(v_rdata));
        end
    endtask

    initial begin
        logic [DW-1:0] rd;

        for (int k = 0; k < N; k++) begin
            port_add[k]  = 32'h1000_0000 * (k + 1) + 32'(k * 4);
            port_wen[k]  = (k % 2 == 0);
            port_be[k]   = 4'h1 << k;
            port_data[k] = 32'hD0D0_0000 | 32'(k);
            in_add[k]    = port_add[k];
            in_wen[k]    = port_wen[k];
            in_be[k]     = port_be[k];
            in_data[k]   = port_data[k];
        end
        rst         = 1'b1;
        in_req      = '0;
        out_gnt     = 1'b0;
        out_r_valid = 1'b0;
        out_r_data  = '0;

        //              rst   req     gnt   rv    win   oreq  outst  err
        // reset, outputs held low even with requests pending
        tv.push_back(mk(1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0));
        tv.push_back(mk(1'b1, 3'b111, 1'b1, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0));
        // all requesting, 1-cycle response latency
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 3'd0, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 3'd1, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 3'd1, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0, 3'd1, 1'b0));
        // only requester 2, then 0 joins and wins after the wrap
        tv.push_back(mk(1'b0, 3'b100, 1'b1, 1'b0, 2'd2, 1'b1, 3'd0, 1'b0));
        tv.push_back(mk(1'b0, 3'b100, 1'b1, 1'b1, 2'd2, 1'b1, 3'd1, 1'b0));
        tv.push_back(mk(1'b0, 3'b101, 1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd1, 1'b0));
        // no handshake: pointer holds at 1, winner follows requests
        tv.push_back(mk(1'b0, 3'b110, 1'b0, 1'b0, 2'd1, 1'b1, 3'd0, 1'b0));
        tv.push_back(mk(1'b0, 3'b101, 1'b0, 1'b0, 2'd2, 1'b1, 3'd0, 1'b0));
        tv.push_back(mk(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 1'b0));
        // fill to MAX_OUTSTANDING, blocked while full even with a pop
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd1, 1'b1, 3'd0, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd2, 1'b1, 3'd1, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 3'd2, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd1, 1'b1, 3'd3, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 3'd4, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b1, 2'd0, 1'b0, 3'd4, 1'b0));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd2, 1'b1, 3'd3, 1'b0));
        // drain to 2, then grant and response together
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd4, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd3, 1'b0));
        tv.push_back(mk(1'b0, 3'b010, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd2, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd2, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd1, 1'b0));
        // unexpected response, sticky error
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1));
        tv.push_back(mk(1'b0, 3'b001, 1'b1, 1'b0, 2'd0, 1'b1, 3'd0, 1'b1));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd1, 1'b1, 3'd1, 1'b1));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd2, 1'b1, 3'd2, 1'b1));
        // reset with 3 in flight; their responses are unexpected, pointer back to 0
        tv.push_back(mk(1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 1'b1));
        tv.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 1'b1));
        tv.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 3'd0, 1'b1));

        foreach (tv[i]) begin
            rd = $urandom();
            drive(tv[i].rst, tv[i].req, tv[i].gnt, tv[i].rv, rd);
            check_outputs(i, tv[i].rst, tv[i].gnt, tv[i].rv, rd,
                          tv[i].oreq, tv[i].win, tv[i].outst, tv[i].err);
        end

        // Hand sequence: single requester per port without grant, payload mux and no grant leak
        for (int p = 0; p < N; p++) begin
            rd = $urandom();
            drive(1'b0, 3'(1 << p), 1'b0, 1'b0, rd);
            check_outputs(100 + p, 1'b0, 1'b0, 1'b0, rd, 1'b1, 2'(p), 3'd1, 1'b1);
        end

        // Hand sequence: drain the last in-flight read to port 0, then idle at zero
        rd = $urandom();
        drive(1'b0, 3'b000, 1'b0, 1'b1, rd);
        check_outputs(200, 1'b0, 1'b0, 1'b1, rd, 1'b0, 2'd0, 3'd1, 1'b1);
        rd = $urandom();
        drive(1'b0, 3'b000, 1'b0, 1'b0, rd);
        check_outputs(201, 1'b0, 1'b0, 1'b0, rd, 1'b0, 2'd0, 3'd0, 1'b1);
        chk("sb_empty", 202, 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hwpe_tcdm_rr_arbiter
